// File: rtl/ifm_pingpong_bank_u6_if.sv
// Bus bundle for the 6-unit ping-pong IFM store.
// The pool-side writer and conv-side reader drive through the master modport.
// The bank store itself connects through the slave modport.
interface ifm_pingpong_bank_u6_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_SIZE_IFM = 5,
  parameter int SEL_WIDTH        = 2
);
  // Writer side
  logic                        ifm_enable_write;
  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write;
  logic [SEL_WIDTH-1:0]        ifm_sel_write;
  logic [DATA_WIDTH-1:0]       data_in_1, data_in_2, data_in_3;
  logic [DATA_WIDTH-1:0]       data_in_4, data_in_5, data_in_6;
  logic                        start_from_previous;
  logic                        conv_ready;
  logic                        overflow;
  // Reader side
  logic                        ifm_enable_read_A, ifm_enable_read_B;
  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A, ifm_address_read_B;
  logic [SEL_WIDTH-1:0]        ifm_sel_read;
  logic [DATA_WIDTH-1:0]       data_out_A_1, data_out_A_2, data_out_A_3;
  logic [DATA_WIDTH-1:0]       data_out_A_4, data_out_A_5, data_out_A_6;
  logic [DATA_WIDTH-1:0]       data_out_B_1, data_out_B_2, data_out_B_3;
  logic [DATA_WIDTH-1:0]       data_out_B_4, data_out_B_5, data_out_B_6;
  logic                        start_to_next;
  logic                        end_from_next;
  // Debug view of the bank-ownership state
  logic                        dbg_rd_busy;
  logic [1:0]                  dbg_full_count;
  logic                        dbg_wr_bank;
  logic                        dbg_rd_bank;

  modport master (
    output ifm_enable_write, ifm_address_write, ifm_sel_write,
    output data_in_1, data_in_2, data_in_3, data_in_4, data_in_5, data_in_6,
    output start_from_previous,
    output ifm_enable_read_A, ifm_enable_read_B,
    output ifm_address_read_A, ifm_address_read_B, ifm_sel_read,
    output end_from_next,
    input  conv_ready, overflow, start_to_next,
    input  data_out_A_1, data_out_A_2, data_out_A_3,
    input  data_out_A_4, data_out_A_5, data_out_A_6,
    input  data_out_B_1, data_out_B_2, data_out_B_3,
    input  data_out_B_4, data_out_B_5, data_out_B_6,
    input  dbg_rd_busy, dbg_full_count, dbg_wr_bank, dbg_rd_bank
  );

  modport slave (
    input  ifm_enable_write, ifm_address_write, ifm_sel_write,
    input  data_in_1, data_in_2, data_in_3, data_in_4, data_in_5, data_in_6,
    input  start_from_previous,
    input  ifm_enable_read_A, ifm_enable_read_B,
    input  ifm_address_read_A, ifm_address_read_B, ifm_sel_read,
    input  end_from_next,
    output conv_ready, overflow, start_to_next,
    output data_out_A_1, data_out_A_2, data_out_A_3,
    output data_out_A_4, data_out_A_5, data_out_A_6,
    output data_out_B_1, data_out_B_2, data_out_B_3,
    output data_out_B_4, data_out_B_5, data_out_B_6,
    output dbg_rd_busy, dbg_full_count, dbg_wr_bank, dbg_rd_bank
  );
endinterface

// File: rtl/ifm_pingpong_bank_u6.sv
// Double-buffered IFM store between the 6-unit pooling stage and the next
// conv layer. Pooling fills the write bank while conv reads the other bank;
// a small ownership FSM swaps the banks on the start/end pulses.
//
// Handshake: start_from_previous is a one-cycle pulse meaning "write bank
// complete"; it is accepted only while conv_ready=1, otherwise it is dropped
// and overflow sticks high. start_to_next is a one-cycle pulse meaning "read
// bank holds a full image". end_from_next is a one-cycle pulse meaning "reader
// done with the read bank"; it is accepted only while the reader owns a bank
// (R_BUSY), otherwise it is dropped and overflow sticks high.
module ifm_pingpong_bank_u6 #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 5,
  parameter int IFM_DEPTH        = 16,
  parameter int NUMBER_OF_UNITS  = 6,
  parameter int SLOTS            = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int SEL_WIDTH        = $clog2(SLOTS)
) (
  input logic                   clk,
  input logic                   reset,
  ifm_pingpong_bank_u6_if.slave bus
);
  localparam int NU    = NUMBER_OF_UNITS;
  localparam int WORDS = IFM_SIZE * IFM_SIZE;
  localparam logic [SEL_WIDTH:0]        SLOTS_L = (SEL_WIDTH + 1)'(SLOTS);
  localparam logic [ADDRESS_SIZE_IFM:0] WORDS_L = (ADDRESS_SIZE_IFM + 1)'(WORDS);

  typedef enum logic {R_IDLE, R_BUSY} rd_state_e;

  rd_state_e       state_q, state_d;
  logic [1:0]      full_count_q, full_count_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic            overflow_q, overflow_d;
  logic            start_to_next_q, start_to_next_d;
  logic            conv_ready;
  logic            start_ok, end_ok;
  logic            wr_en;
  logic            rd_ok_a, rd_ok_b;

  logic [DATA_WIDTH-1:0] din        [NU];
  logic [DATA_WIDTH-1:0] data_a_q   [NU];
  logic [DATA_WIDTH-1:0] data_a_d   [NU];
  logic [DATA_WIDTH-1:0] data_b_q   [NU];
  logic [DATA_WIDTH-1:0] data_b_d   [NU];
  // Storage: [unit][bank][slot][word]; contents are never reset.
  logic [DATA_WIDTH-1:0] mem [NU][2][SLOTS][WORDS];

  assign din[0] = bus.data_in_1;
  assign din[1] = bus.data_in_2;
  assign din[2] = bus.data_in_3;
  assign din[3] = bus.data_in_4;
  assign din[4] = bus.data_in_5;
  assign din[5] = bus.data_in_6;

  // Writer may only proceed while at least one bank is not holding a full image.
  assign conv_ready = (full_count_q < 2'd2);
  assign start_ok   = bus.start_from_previous && conv_ready;
  assign end_ok     = bus.end_from_next && (state_q == R_BUSY);

  // Bank ownership: counts full banks, flips pointers and announces images.
  always_comb begin
    state_d         = state_q;
    full_count_d    = full_count_q;
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    overflow_d      = overflow_q;
    start_to_next_d = 1'b0;

    if (bus.start_from_previous && !conv_ready) overflow_d = 1'b1;
    if (bus.end_from_next && (state_q == R_IDLE)) overflow_d = 1'b1;
    if (start_ok) wr_bank_d = ~wr_bank_q;
    if (end_ok)   rd_bank_d = ~rd_bank_q;

    case ({start_ok, end_ok})
      2'b10:   full_count_d = full_count_q + 2'd1;
      2'b01:   full_count_d = full_count_q - 2'd1;
      default: full_count_d = full_count_q;
    endcase

    case (state_q)
      R_IDLE: begin
        if (full_count_q != 2'd0) begin
          start_to_next_d = 1'b1;
          state_d         = R_BUSY;
        end
      end
      R_BUSY: begin
        if (end_ok) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Ownership state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= R_IDLE;
      full_count_q    <= 2'd0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      overflow_q      <= 1'b0;
      start_to_next_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      full_count_q    <= full_count_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      overflow_q      <= overflow_d;
      start_to_next_q <= start_to_next_d;
    end
  end

  // Decode write enable and the read-range checks; out-of-range accesses are dropped.
  always_comb begin
    wr_en   = bus.ifm_enable_write && conv_ready &&
              ({1'b0, bus.ifm_sel_write} < SLOTS_L) &&
              ({1'b0, bus.ifm_address_write} < WORDS_L);
    rd_ok_a = ({1'b0, bus.ifm_sel_read} < SLOTS_L) &&
              ({1'b0, bus.ifm_address_read_A} < WORDS_L);
    rd_ok_b = ({1'b0, bus.ifm_sel_read} < SLOTS_L) &&
              ({1'b0, bus.ifm_address_read_B} < WORDS_L);
  end

  // All six units store their word at the same (bank, slot, address).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int u = 0; u < NU; u++) begin
        mem[u][wr_bank_q][bus.ifm_sel_write][bus.ifm_address_write] <= din[u];
      end
    end
  end

  // Next read data: fetch on strobe (0 when out of range), otherwise hold.
  always_comb begin
    for (int u = 0; u < NU; u++) begin
      data_a_d[u] = data_a_q[u];
      data_b_d[u] = data_b_q[u];
      if (bus.ifm_enable_read_A) begin
        data_a_d[u] = rd_ok_a ? mem[u][rd_bank_q][bus.ifm_sel_read][bus.ifm_address_read_A]
                              : '0;
      end
      if (bus.ifm_enable_read_B) begin
        data_b_d[u] = rd_ok_b ? mem[u][rd_bank_q][bus.ifm_sel_read][bus.ifm_address_read_B]
                              : '0;
      end
    end
  end

  // Registered read ports, one cycle after the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int u = 0; u < NU; u++) begin
        data_a_q[u] <= '0;
        data_b_q[u] <= '0;
      end
    end else begin
      for (int u = 0; u < NU; u++) begin
        data_a_q[u] <= data_a_d[u];
        data_b_q[u] <= data_b_d[u];
      end
    end
  end

  assign bus.conv_ready     = conv_ready;
  assign bus.overflow       = overflow_q;
  assign bus.start_to_next  = start_to_next_q;
  assign bus.dbg_rd_busy    = (state_q == R_BUSY);
  assign bus.dbg_full_count = full_count_q;
  assign bus.dbg_wr_bank    = wr_bank_q;
  assign bus.dbg_rd_bank    = rd_bank_q;

  assign bus.data_out_A_1 = data_a_q[0];
  assign bus.data_out_A_2 = data_a_q[1];
  assign bus.data_out_A_3 = data_a_q[2];
  assign bus.data_out_A_4 = data_a_q[3];
  assign bus.data_out_A_5 = data_a_q[4];
  assign bus.data_out_A_6 = data_a_q[5];
  assign bus.data_out_B_1 = data_b_q[0];
  assign bus.data_out_B_2 = data_b_q[1];
  assign bus.data_out_B_3 = data_b_q[2];
  assign bus.data_out_B_4 = data_b_q[3];
  assign bus.data_out_B_5 = data_b_q[4];
  assign bus.data_out_B_6 = data_b_q[5];
endmodule

// File: tb/tb_ifm_pingpong_bank_u6.sv
// Directed bench for the 6-unit ping-pong IFM store.
// Word pattern: {image, unit, slot, address} one byte each.
module tb_ifm_pingpong_bank_u6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ifm_pingpong_bank_u6_if #(.DATA_WIDTH(32), .ADDRESS_SIZE_IFM(5), .SEL_WIDTH(2)) bus ();

  ifm_pingpong_bank_u6 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] din   [6];
  logic [31:0] out_a [6];
  logic [31:0] out_b [6];

  assign bus.data_in_1 = din[0];
  assign bus.data_in_2 = din[1];
  assign bus.data_in_3 = din[2];
  assign bus.data_in_4 = din[3];
  assign bus.data_in_5 = din[4];
  assign bus.data_in_6 = din[5];
  assign out_a[0] = bus.data_out_A_1;
  assign out_a[1] = bus.data_out_A_2;
  assign out_a[2] = bus.data_out_A_3;
  assign out_a[3] = bus.data_out_A_4;
  assign out_a[4] = bus.data_out_A_5;
  assign out_a[5] = bus.data_out_A_6;
  assign out_b[0] = bus.data_out_B_1;
  assign out_b[1] = bus.data_out_B_2;
  assign out_b[2] = bus.data_out_B_3;
  assign out_b[3] = bus.data_out_B_4;
  assign out_b[4] = bus.data_out_B_5;
  assign out_b[5] = bus.data_out_B_6;

  // Clock
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int img, input int u, input int s, input int a);
    if (s >= 3 || a >= 25) return 32'h0;
    return 32'((img << 24) | (u << 16) | (s << 8) | a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ifm_enable_write    = 1'b0;
    bus.ifm_address_write   = '0;
    bus.ifm_sel_write       = '0;
    bus.start_from_previous = 1'b0;
    bus.ifm_enable_read_A   = 1'b0;
    bus.ifm_enable_read_B   = 1'b0;
    bus.ifm_address_read_A  = '0;
    bus.ifm_address_read_B  = '0;
    bus.ifm_sel_read        = '0;
    bus.end_from_next       = 1'b0;
    for (int u = 0; u < 6; u++) din[u] = '0;
  endtask

  // Driver: one full image, every slot and address, all units.
  task automatic write_image(input int img);
    for (int s = 0; s < 3; s++) begin
      for (int a = 0; a < 25; a++) begin
        bus.ifm_enable_write  = 1'b1;
        bus.ifm_sel_write     = 2'(s);
        bus.ifm_address_write = 5'(a);
        for (int u = 0; u < 6; u++) din[u] = pat(img, u + 1, s, a);
        tick();
      end
    end
    bus.ifm_enable_write = 1'b0;
  endtask

  task automatic write_one(input int s, input int a, input logic [31:0] d);
    bus.ifm_enable_write  = 1'b1;
    bus.ifm_sel_write     = 2'(s);
    bus.ifm_address_write = 5'(a);
    for (int u = 0; u < 6; u++) din[u] = d;
    tick();
    bus.ifm_enable_write = 1'b0;
  endtask

  task automatic pulse(input logic do_start, input logic do_end);
    bus.start_from_previous = do_start;
    bus.end_from_next       = do_end;
    tick();
    bus.start_from_previous = 1'b0;
    bus.end_from_next       = 1'b0;
  endtask

  // Strobe both ports once and compare every unit one cycle later.
  task automatic read_check(input string name, input int s, input int aa, input int ab, input int img);
    logic [31:0] ea, eb;
    bus.ifm_sel_read       = 2'(s);
    bus.ifm_address_read_A = 5'(aa);
    bus.ifm_address_read_B = 5'(ab);
    bus.ifm_enable_read_A  = 1'b1;
    bus.ifm_enable_read_B  = 1'b1;
    tick();
    bus.ifm_enable_read_A  = 1'b0;
    bus.ifm_enable_read_B  = 1'b0;
    for (int u = 0; u < 6; u++) begin
      ea = pat(img, u + 1, s, aa);
      eb = pat(img, u + 1, s, ab);
      checks++;
      if (out_a[u] !== ea) begin
        errors++;
        $display("FAIL %s port A unit %0d: got %h expected %h", name, u + 1, out_a[u], ea);
      end
      checks++;
      if (out_b[u] !== eb) begin
        errors++;
        $display("FAIL %s port B unit %0d: got %h expected %h", name, u + 1, out_b[u], eb);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.conv_ready !== 1'b1) begin errors++; $display("FAIL reset conv_ready: got %b expected 1", bus.conv_ready); end
    checks++;
    if (bus.start_to_next !== 1'b0) begin errors++; $display("FAIL reset start_to_next: got %b expected 0", bus.start_to_next); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b expected 0", bus.overflow); end
    checks++;
    if (bus.dbg_full_count !== 2'd0) begin errors++; $display("FAIL reset full_count: got %0d expected 0", bus.dbg_full_count); end
    checks++;
    if (out_a[0] !== 32'h0 || out_b[5] !== 32'h0) begin
      errors++; $display("FAIL reset data_out: got %h/%h expected 0/0", out_a[0], out_b[5]);
    end
  endtask

  task automatic test_end_in_idle();
    pulse(1'b0, 1'b1);
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL end_idle overflow: got %b expected 1", bus.overflow); end
    checks++;
    if (bus.dbg_full_count !== 2'd0 || bus.dbg_rd_bank !== 1'b0) begin
      errors++; $display("FAIL end_idle state: got count %0d rd_bank %b expected 0/0", bus.dbg_full_count, bus.dbg_rd_bank);
    end
  endtask

  task automatic test_single_image();
    write_image(1);
    pulse(1'b1, 1'b0);
    checks++;
    if (bus.start_to_next !== 1'b0 || bus.dbg_full_count !== 2'd1) begin
      errors++; $display("FAIL single accept: got stn %b count %0d expected 0/1", bus.start_to_next, bus.dbg_full_count);
    end
    tick();
    checks++;
    if (bus.start_to_next !== 1'b1 || bus.dbg_rd_busy !== 1'b1) begin
      errors++; $display("FAIL single stn_pulse: got stn %b busy %b expected 1/1", bus.start_to_next, bus.dbg_rd_busy);
    end
    tick();
    checks++;
    if (bus.start_to_next !== 1'b0) begin errors++; $display("FAIL single stn_drop: got %b expected 0", bus.start_to_next); end
    read_check("img1_s1", 1, 3, 24, 1);
    read_check("img1_s2", 2, 0, 17, 1);
    // Strobes low: outputs must hold while addresses move.
    bus.ifm_address_read_A = 5'd9;
    bus.ifm_address_read_B = 5'd4;
    tick();
    checks++;
    if (out_a[2] !== pat(1, 3, 2, 0) || out_b[4] !== pat(1, 5, 2, 17)) begin
      errors++; $display("FAIL hold: got %h/%h expected %h/%h", out_a[2], out_b[4], pat(1, 3, 2, 0), pat(1, 5, 2, 17));
    end
  endtask

  task automatic test_fill_overflow();
    write_image(2);
    pulse(1'b1, 1'b0);
    checks++;
    if (bus.conv_ready !== 1'b0 || bus.dbg_full_count !== 2'd2 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL fill second: got ready %b count %0d ovf %b expected 0/2/0",
                         bus.conv_ready, bus.dbg_full_count, bus.overflow);
    end
    write_image(3);
    pulse(1'b1, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.dbg_full_count !== 2'd2 || bus.dbg_wr_bank !== 1'b0) begin
      errors++; $display("FAIL fill third: got ovf %b count %0d wr_bank %b expected 1/2/0",
                         bus.overflow, bus.dbg_full_count, bus.dbg_wr_bank);
    end
    read_check("bank_unchanged", 0, 5, 12, 1);
  endtask

  task automatic test_end_full();
    pulse(1'b0, 1'b1);
    checks++;
    if (bus.conv_ready !== 1'b1 || bus.dbg_full_count !== 2'd1 || bus.dbg_rd_bank !== 1'b1) begin
      errors++; $display("FAIL end_full release: got ready %b count %0d rd_bank %b expected 1/1/1",
                         bus.conv_ready, bus.dbg_full_count, bus.dbg_rd_bank);
    end
    checks++;
    if (bus.start_to_next !== 1'b0) begin errors++; $display("FAIL end_full stn_early: got %b expected 0", bus.start_to_next); end
    tick();
    checks++;
    if (bus.start_to_next !== 1'b1) begin errors++; $display("FAIL end_full stn_pulse: got %b expected 1", bus.start_to_next); end
    tick();
    checks++;
    if (bus.start_to_next !== 1'b0 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL end_full after: got stn %b ovf %b expected 0/1", bus.start_to_next, bus.overflow);
    end
    read_check("img2", 2, 24, 7, 2);
  endtask

  task automatic test_reset_busy();
    pulse(1'b1, 1'b0);
    checks++;
    if (bus.dbg_full_count !== 2'd2 || bus.dbg_rd_busy !== 1'b1) begin
      errors++; $display("FAIL rst_busy setup: got count %0d busy %b expected 2/1", bus.dbg_full_count, bus.dbg_rd_busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.conv_ready !== 1'b1 || bus.start_to_next !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL rst_busy outputs: got ready %b stn %b ovf %b expected 1/0/0",
                         bus.conv_ready, bus.start_to_next, bus.overflow);
    end
    checks++;
    if (bus.dbg_full_count !== 2'd0 || bus.dbg_rd_busy !== 1'b0 || out_a[0] !== 32'h0) begin
      errors++; $display("FAIL rst_busy state: got count %0d busy %b data %h expected 0/0/0",
                         bus.dbg_full_count, bus.dbg_rd_busy, out_a[0]);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    write_image(4);
    pulse(1'b1, 1'b0);
    tick();
    checks++;
    if (bus.start_to_next !== 1'b1) begin errors++; $display("FAIL same setup stn: got %b expected 1", bus.start_to_next); end
    write_image(5);
    pulse(1'b1, 1'b1);
    checks++;
    if (bus.dbg_full_count !== 2'd1 || bus.dbg_wr_bank !== 1'b0 || bus.dbg_rd_bank !== 1'b1) begin
      errors++; $display("FAIL same pointers: got count %0d wr %b rd %b expected 1/0/1",
                         bus.dbg_full_count, bus.dbg_wr_bank, bus.dbg_rd_bank);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL same overflow: got %b expected 0", bus.overflow); end
    tick();
    checks++;
    if (bus.start_to_next !== 1'b1) begin errors++; $display("FAIL same stn: got %b expected 1", bus.start_to_next); end
    read_check("img5", 0, 10, 20, 5);
  endtask

  task automatic test_out_of_range();
    write_one(3, 0, 32'hDEAD_BEEF);
    write_one(0, 25, 32'hDEAD_BEEF);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    tick();
    checks++;
    if (bus.dbg_rd_bank !== 1'b0 || bus.start_to_next !== 1'b1) begin
      errors++; $display("FAIL range setup: got rd %b stn %b expected 0/1", bus.dbg_rd_bank, bus.start_to_next);
    end
    read_check("img4", 0, 0, 24, 4);
    read_check("sel3", 3, 0, 1, 4);
    read_check("addr25", 1, 25, 2, 4);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_end_in_idle();
    test_reset();
    test_single_image();
    test_fill_overflow();
    test_end_full();
    test_reset_busy();
    test_same_cycle();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
